demux_capture_36: RTL and testbench

DEMUX_CAPTURE_36 -- requirements
Module: demux_capture_36

---
 rtl/demux_capture_36_pkg.sv | 24 ++
 rtl/demux_capture_36_if.sv | 25 ++
 rtl/demux_capture_ctrl.sv | 101 ++++++++++
 rtl/demux_capture_36.sv | 99 +++++++++
 tb/tb_demux_capture_36.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/demux_capture_36_pkg.sv
// Shared definitions for the demux capture block: FSM states, default sizes, parity polarity.
// Optional parity stage is enabled by defining DEMUX_CAPTURE_PARITY_EN.
package demux_capture_36_pkg;

    localparam int DEF_WIDTH = 36;
    localparam int DEF_SEL_W = 6;

    // 0 selects even parity: data bits plus parity bit must contain an even number of ones.
    localparam logic PARITY_POL = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
`ifdef DEMUX_CAPTURE_PARITY_EN
        , ST_PAR = 2'd3
`endif
    } state_t;

    function automatic logic parity_mismatch(input logic data_xor, input logic par_bit);
        return data_xor ^ par_bit ^ PARITY_POL;
    endfunction

endpackage

// File: rtl/demux_capture_36_if.sv
// Bus between the demux capture block and its user: frame request, serial sample stream,
// selector index and the captured frame with status.
interface demux_capture_36_if #(
    parameter int WIDTH = demux_capture_36_pkg::DEF_WIDTH,
    parameter int SEL_W = demux_capture_36_pkg::DEF_SEL_W
);
    logic             start;
    logic             sample_en;
    logic             serial_in;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] data_out;
    logic             busy;
    logic             done;
    logic             parity_err;

    modport master (
        output start, sample_en, serial_in,
        input  sel, data_out, busy, done, parity_err
    );

    modport slave (
        input  start, sample_en, serial_in,
        output sel, data_out, busy, done, parity_err
    );
endinterface

// File: rtl/demux_capture_ctrl.sv
// Frame sequencer for the demux capture block: FSM and selector index counter.
// With DEMUX_CAPTURE_PARITY_EN defined, an extra PAR state takes one parity sample.
module demux_capture_ctrl
    import demux_capture_36_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             sample_en,
`ifdef DEMUX_CAPTURE_PARITY_EN
    output logic             par_take,
`endif
    output logic             frame_start,
    output logic             capture,
    output logic             in_done,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             done
);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [SEL_W-1:0] sel_q, sel_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            sel_q <= '0;
        end else begin
            state <= state_nxt;
            sel_q <= sel_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        sel_nxt     = sel_q;
        frame_start = 1'b0;
        capture     = 1'b0;
`ifdef DEMUX_CAPTURE_PARITY_EN
        par_take    = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                sel_nxt = '0;
                if (start) begin
                    frame_start = 1'b1;
                    state_nxt   = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (sample_en) begin
                    capture = 1'b1;
                    // The last index returns sel to 0 instead of wrapping past WIDTH-1.
                    if (sel_q == LAST_SEL) begin
                        sel_nxt = '0;
`ifdef DEMUX_CAPTURE_PARITY_EN
                        state_nxt = ST_PAR;
`else
                        state_nxt = ST_DONE;
`endif
                    end else begin
                        sel_nxt = sel_q + 1'b1;
                    end
                end
            end
`ifdef DEMUX_CAPTURE_PARITY_EN
            ST_PAR: begin
                sel_nxt = '0;
                if (sample_en) begin
                    par_take  = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                sel_nxt   = '0;
                state_nxt = ST_IDLE;
            end
            default: begin
                sel_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Status outputs decode the state register only, so no input reaches them combinationally.
    assign in_done = (state == ST_DONE);
    assign done    = in_done;
`ifdef DEMUX_CAPTURE_PARITY_EN
    assign busy    = (state == ST_SCAN) || (state == ST_PAR);
`else
    assign busy    = (state == ST_SCAN);
`endif
    assign sel     = sel_q;

endmodule

// File: rtl/demux_capture_36.sv
// Serial capture behind a 36:1 selector: walks sel, assembles the frame in a shadow register
// and publishes it on data_out at frame end. Optional parity check: DEMUX_CAPTURE_PARITY_EN.
module demux_capture_36
    import demux_capture_36_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic               clk,
    input  logic               reset_n,
    demux_capture_36_if.slave  bus
);

    localparam logic [SEL_W-1:0] TOP_IDX = SEL_W'(WIDTH - 1);

    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] data_q;
    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] wr_idx;
    logic             frame_start;
    logic             capture;
    logic             in_done;
    logic             busy;
    logic             done;
`ifdef DEMUX_CAPTURE_PARITY_EN
    logic             par_take;
    logic             par_bit;
    logic             perr_q;
`endif

    demux_capture_ctrl #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_ctrl (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (bus.start),
        .sample_en   (bus.sample_en),
`ifdef DEMUX_CAPTURE_PARITY_EN
        .par_take    (par_take),
`endif
        .frame_start (frame_start),
        .capture     (capture),
        .in_done     (in_done),
        .sel         (sel),
        .busy        (busy),
        .done        (done)
    );

    // sel=0 lands in the MSB, so the first sampled bit ends up in data_out[WIDTH-1].
    assign wr_idx = TOP_IDX - sel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow <= '0;
        end else if (frame_start) begin
            shadow <= '0;
        end else if (capture) begin
            shadow[wr_idx] <= bus.serial_in;
        end
    end

    // data_out only moves in DONE, so a frame in progress never leaks out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
        end else if (in_done) begin
            data_q <= shadow;
        end
    end

`ifdef DEMUX_CAPTURE_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par_bit <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            if (frame_start) begin
                par_bit <= 1'b0;
            end else if (par_take) begin
                par_bit <= bus.serial_in;
            end
            if (in_done) begin
                perr_q <= parity_mismatch(^shadow, par_bit);
            end
        end
    end

    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.sel      = sel;
    assign bus.data_out = data_q;
    assign bus.busy     = busy;
    assign bus.done     = done;

endmodule

// File: tb/tb_demux_capture_36.sv
// Directed bench for demux_capture_36; parity cases follow DEMUX_CAPTURE_PARITY_EN.
module tb_demux_capture_36;

`ifdef DEMUX_CAPTURE_PARITY_EN
    localparam int PX = 1;
`else
    localparam int PX = 0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_total = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    demux_capture_36_if #(.WIDTH(36), .SEL_W(6)) bus ();

    demux_capture_36 #(.WIDTH(36), .SEL_W(6)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one frame from IDLE; serial_in presents pat[35-k] for the k-th sample,
    // then pbit for the parity sample when that stage exists.
    task automatic run_frame(input string tag, input logic [35:0] pat, input bit toggle,
                             input int restart_k, input logic pbit,
                             input int exp_lat, input int exp_busy);
        int k = 0;
        int lat = 0;
        int busy_cnt = 0;
        int done_cnt = 0;
        bit seen = 1'b0;
        logic en;
        logic [35:0] prev;
        prev = bus.data_out;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            lat++;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                seen = 1'b1;
                bus.sample_en = 1'b0;
                bus.start = 1'b0;
            end else begin
                if (k < 36) check({tag, "_sel"}, 64'(bus.sel), 64'(k));
                if (k == 35) check({tag, "_hold"}, 64'(bus.data_out), 64'(prev));
                bus.start = (k == restart_k);
                en = toggle ? ((c % 2) == 0) : 1'b1;
                bus.sample_en = en;
                bus.serial_in = (k < 36) ? pat[35 - k] : pbit;
                if (en) k++;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        bus.sample_en = 1'b0;
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
        check({tag, "_data"}, 64'(bus.data_out), 64'(pat));
        check({tag, "_sel_idle"}, 64'(bus.sel), 64'd0);
        check({tag, "_busy_idle"}, 64'(bus.busy), 64'd0);
        for (int i = 0; i < 4; i++) begin
            if (bus.done) done_cnt++;
            @(posedge clk); #1;
        end
        check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
    endtask

    initial begin
        int done_cnt;
        bus.start = 1'b0;
        bus.sample_en = 1'b0;
        bus.serial_in = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_sel", 64'(bus.sel), 64'd0);
        check("rst_data", 64'(bus.data_out), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_perr", 64'(bus.parity_err), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_frame("a5_cont", 36'hA5A5A5A5A, 1'b0, -1, 1'b0, 37 + PX, 36 + PX);
        check("a5_perr", 64'(bus.parity_err), 64'd0);
        run_frame("a5_toggle", 36'hA5A5A5A5A, 1'b1, -1, 1'b0, 72 + 2 * PX, 71 + 2 * PX);
        run_frame("restart", 36'h123456789, 1'b0, 10, 1'b1, 37 + PX, 36 + PX);
        run_frame("walk_msb", 36'h800000000, 1'b0, -1, 1'b1, 37 + PX, 36 + PX);
        check("walk_msb_bit35", 64'(bus.data_out[35]), 64'd1);
        run_frame("walk_lsb", 36'h000000001, 1'b0, -1, 1'b1, 37 + PX, 36 + PX);
        check("walk_lsb_bit0", 64'(bus.data_out[0]), 64'd1);
        check("walk_lsb_bit35", 64'(bus.data_out[35]), 64'd0);
`ifdef DEMUX_CAPTURE_PARITY_EN
        check("par_good", 64'(bus.parity_err), 64'd0);
        run_frame("par_bad", 36'h000000001, 1'b0, -1, 1'b0, 38, 37);
        check("par_bad_perr", 64'(bus.parity_err), 64'd1);
`else
        check("perr_tied", 64'(bus.parity_err), 64'd0);
`endif

        // Abort a frame mid-scan with an asynchronous reset.
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.sample_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            bus.serial_in = k[0];
            @(posedge clk); #1;
        end
        check("abort_sel_before", 64'(bus.sel), 64'd20);
        check("abort_busy_before", 64'(bus.busy), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("abort_sel", 64'(bus.sel), 64'd0);
        check("abort_data", 64'(bus.data_out), 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_perr", 64'(bus.parity_err), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("post_rst_sel", 64'(bus.sel), 64'd0);
            if (bus.done) done_cnt++;
        end
        check("post_rst_done", 64'(done_cnt), 64'd0);
        check("post_rst_busy", 64'(bus.busy), 64'd0);
        bus.sample_en = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
